// File: rtl/branch_target_buffer.sv
// rtl/branch_target_buffer.sv - direct-mapped BTB with 2-bit direction state per entry.
// Optional BTB_BYPASS_EN forwards a same-cycle colliding update to the lookup outputs.

module dynamic_branch_predictor (
    input  logic [1:0] current_state,
    input  logic       mispredicted,
    output logic [1:0] next_state
);
    // 00 strong-taken, 01 weak-taken, 10 strong-not-taken, 11 weak-not-taken
    always_comb begin
        next_state = current_state;
        case (current_state)
            2'b00: next_state = mispredicted ? 2'b01 : 2'b00;
            2'b01: next_state = mispredicted ? 2'b10 : 2'b00;
            2'b10: next_state = mispredicted ? 2'b11 : 2'b10;
            2'b11: next_state = mispredicted ? 2'b00 : 2'b10;
            default: next_state = 2'b01;
        endcase
    end
endmodule

module branch_target_buffer #(
    parameter int ENTRIES = 16,
    parameter int XLEN    = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            btb_hit,
    output logic            predict_taken,
    output logic [XLEN-1:0] predict_target,
    input  logic            update_valid,
    input  logic [XLEN-1:0] update_pc,
    input  logic [XLEN-1:0] update_target,
    input  logic            update_taken,
    input  logic            update_mispredicted
);
    localparam int IDXW = $clog2(ENTRIES);
    localparam int TAGW = XLEN - IDXW - 2;

    logic [ENTRIES-1:0] valid_q;
    logic [TAGW-1:0]    tag_q    [ENTRIES];
    logic [XLEN-1:0]    target_q [ENTRIES];
    logic [1:0]         state_q  [ENTRIES];

    logic [IDXW-1:0] lk_idx;
    logic [TAGW-1:0] lk_tag;
    logic [IDXW-1:0] upd_idx;
    logic [TAGW-1:0] upd_tag;
    logic            upd_hit;
    logic [1:0]      upd_next_state;

    logic            unused_pc_lo;

    assign lk_idx  = lookup_pc[IDXW+1:2];
    assign lk_tag  = lookup_pc[XLEN-1:IDXW+2];
    assign upd_idx = update_pc[IDXW+1:2];
    assign upd_tag = update_pc[XLEN-1:IDXW+2];
    assign unused_pc_lo = ^{lookup_pc[1:0], update_pc[1:0]};

    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    dynamic_branch_predictor u_dbp (
        .current_state (state_q[upd_idx]),
        .mispredicted  (update_mispredicted),
        .next_state    (upd_next_state)
    );

    // Single write port: reset beats flush, flush beats update.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                state_q[i]  <= 2'b01;
            end
        end else if (flush) begin
            valid_q <= '0;
        end else if (update_valid) begin
            if (upd_hit) begin
                state_q[upd_idx] <= upd_next_state;
                if (update_taken) begin
                    target_q[upd_idx] <= update_target;
                end
            end else if (update_taken) begin
                valid_q[upd_idx]  <= 1'b1;
                tag_q[upd_idx]    <= upd_tag;
                target_q[upd_idx] <= update_target;
                state_q[upd_idx]  <= 2'b01;
            end
        end
    end

    logic            lk_hit;
    logic [1:0]      lk_state;
    logic [XLEN-1:0] lk_target;

    always_comb begin
        lk_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        lk_state  = state_q[lk_idx];
        lk_target = target_q[lk_idx];
`ifdef BTB_BYPASS_EN
        // Show the post-write view of an entry being written this very cycle.
        if (update_valid && !flush && !rst && (upd_idx == lk_idx) && (upd_tag == lk_tag)) begin
            if (upd_hit) begin
                lk_state = upd_next_state;
                if (update_taken) begin
                    lk_target = update_target;
                end
            end else if (update_taken) begin
                lk_hit    = 1'b1;
                lk_state  = 2'b01;
                lk_target = update_target;
            end
        end
`endif
        btb_hit        = lk_hit;
        predict_taken  = lk_hit && !lk_state[1];
        predict_target = lk_hit ? lk_target : '0;
    end
endmodule

// File: tb/tb_branch_target_buffer.sv
// tb/tb_branch_target_buffer.sv - directed and randomized checks of branch_target_buffer against a table model.
module tb_branch_target_buffer;
    localparam int ENTRIES = 16;
    localparam int XLEN    = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            flush = 1'b0;
    logic [XLEN-1:0] lookup_pc = '0;
    logic            btb_hit;
    logic            predict_taken;
    logic [XLEN-1:0] predict_target;
    logic            update_valid = 1'b0;
    logic [XLEN-1:0] update_pc = '0;
    logic [XLEN-1:0] update_target = '0;
    logic            update_taken = 1'b0;
    logic            update_mispredicted = 1'b0;

    int checks = 0;
    int errors = 0;
    bit model_ok = 1'b0;

    branch_target_buffer #(.ENTRIES(ENTRIES), .XLEN(XLEN)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .flush               (flush),
        .lookup_pc           (lookup_pc),
        .btb_hit             (btb_hit),
        .predict_taken       (predict_taken),
        .predict_target      (predict_target),
        .update_valid        (update_valid),
        .update_pc           (update_pc),
        .update_target       (update_target),
        .update_taken        (update_taken),
        .update_mispredicted (update_mispredicted)
    );

    always #5 clk = ~clk;

    // Each slot remembers the full word address of its occupant.
    typedef struct packed {
        logic        valid;
        logic [29:0] word;
        logic [31:0] target;
        logic [1:0]  state;
    } ent_t;

    ent_t model [ENTRIES];

    function automatic int idx_of(logic [31:0] pc);
        return int'(pc[31:2] % ENTRIES);
    endfunction

    function automatic ent_t apply(ent_t e, logic [31:0] pc, logic [31:0] tgt, logic tk, logic mp);
        ent_t r;
        r = e;
        if (e.valid && e.word == pc[31:2]) begin
            r.state = mp ? 2'(e.state + 2'd1) : (e.state & 2'b10);
            if (tk) r.target = tgt;
        end else if (tk) begin
            r.valid  = 1'b1;
            r.word   = pc[31:2];
            r.target = tgt;
            r.state  = 2'b01;
        end
        return r;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) model[i] <= '{valid: 1'b0, word: 30'd0, target: 32'd0, state: 2'b01};
            model_ok <= 1'b1;
        end else if (flush) begin
            for (int i = 0; i < ENTRIES; i++) model[i].valid <= 1'b0;
        end else if (update_valid) begin
            model[idx_of(update_pc)] <= apply(model[idx_of(update_pc)], update_pc, update_target,
                                              update_taken, update_mispredicted);
        end
    end

    always @(negedge clk) begin
        ent_t e;
        logic eh;
        if (model_ok && !rst) begin
            e = model[idx_of(lookup_pc)];
`ifdef BTB_BYPASS_EN
            if (update_valid && !flush && update_pc[31:2] == lookup_pc[31:2])
                e = apply(e, update_pc, update_target, update_taken, update_mispredicted);
`endif
            eh = e.valid && (e.word == lookup_pc[31:2]);
            chk("cmp_hit", 64'(btb_hit), 64'(eh));
            chk("cmp_taken", 64'(predict_taken), 64'(eh && (e.state == 2'b00 || e.state == 2'b01)));
            chk("cmp_target", 64'(predict_target), eh ? 64'(e.target) : 64'd0);
        end
    end

    task automatic step(logic r, logic f, logic uv, logic [31:0] upc, logic [31:0] utg,
                        logic ut, logic um, logic [31:0] lpc);
        @(posedge clk);
        #1;
        rst = r; flush = f; update_valid = uv; update_pc = upc; update_target = utg;
        update_taken = ut; update_mispredicted = um; lookup_pc = lpc;
        @(negedge clk);
    endtask

    task automatic look(string name, logic [31:0] lpc, logic eh, logic et, logic [31:0] etg);
        step(0, 0, 0, 0, 0, 0, 0, lpc);
        chk({name, "_hit"}, 64'(btb_hit), 64'(eh));
        chk({name, "_taken"}, 64'(predict_taken), 64'(et));
        chk({name, "_target"}, 64'(predict_target), 64'(etg));
    endtask

    logic [31:0] pcs [8] = '{32'h100, 32'h140, 32'h104, 32'h300, 32'h2104, 32'h180, 32'h13c, 32'h344};

    initial begin
        step(1, 0, 1, 32'h100, 32'h999, 1, 0, 32'h100);
        step(1, 0, 0, 0, 0, 0, 0, 32'h100);
        look("reset_lookup", 32'h100, 0, 0, 32'h0);

        step(0, 0, 1, 32'h100, 32'h200, 1, 1, 32'h0);
        look("alloc", 32'h100, 1, 1, 32'h200);
        chk("model_alloc_state", 64'(model[0].state), 64'h1);

        step(0, 0, 1, 32'h100, 32'h0, 0, 1, 32'h100);
        step(0, 0, 1, 32'h100, 32'h0, 0, 0, 32'h100);
        chk("model_state_after_mispred", 64'(model[0].state), 64'h2);
        look("not_taken", 32'h100, 1, 0, 32'h200);
        chk("model_state_after_correct", 64'(model[0].state), 64'h2);

        step(0, 0, 1, 32'h140, 32'h500, 1, 1, 32'h0);
        look("alias_old", 32'h100, 0, 0, 32'h0);
        look("alias_new", 32'h140, 1, 1, 32'h500);
        step(0, 0, 1, 32'h140, 32'h540, 1, 0, 32'h0);
        look("hit_retarget", 32'h141, 1, 1, 32'h540);

        step(0, 1, 1, 32'h180, 32'h600, 1, 1, 32'h0);
        look("flush_old", 32'h140, 0, 0, 32'h0);
        look("flush_drop", 32'h180, 0, 0, 32'h0);

        step(0, 0, 1, 32'h300, 32'h700, 1, 1, 32'h300);
`ifdef BTB_BYPASS_EN
        chk("bypass_same_cycle_hit", 64'(btb_hit), 64'h1);
        chk("bypass_same_cycle_target", 64'(predict_target), 64'h700);
`else
        chk("nobypass_same_cycle_hit", 64'(btb_hit), 64'h0);
        chk("nobypass_same_cycle_target", 64'(predict_target), 64'h0);
`endif
        look("alloc_next_cycle", 32'h300, 1, 1, 32'h700);

        step(0, 0, 1, 32'h344, 32'h800, 0, 1, 32'h0);
        look("nt_miss_no_alloc", 32'h344, 0, 0, 32'h0);

        step(1, 0, 1, 32'h300, 32'h900, 1, 0, 32'h300);
        look("reset_midop", 32'h300, 0, 0, 32'h0);

        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 31) == 0),
                 ($urandom_range(0, 2) != 0),
                 pcs[$urandom_range(0, 7)] + 32'($urandom_range(0, 3)),
                 {$urandom_range(0, 65535), 2'b00},
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 pcs[$urandom_range(0, 7)] + 32'($urandom_range(0, 3)));
        end
        step(0, 0, 0, 0, 0, 0, 0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/branch_target_buffer.md
BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

Interface
REQ-001 SHALL have parameter ENTRIES, default 16, number of direct-mapped entries (power of two, 2..256).
REQ-002 SHALL have parameter XLEN, default 32, PC and target width.
REQ-003 SHALL have port clk, input, 1, sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, reset; reset is synchronous and active-high.
REQ-005 SHALL have port flush, input, 1, invalidate all entries.
REQ-006 SHALL have port lookup_pc, input, XLEN, fetch-stage PC to predict.
REQ-007 SHALL have port btb_hit, output, 1, lookup_pc matches a valid entry.
REQ-008 SHALL have port predict_taken, output, 1, predicted direction for lookup_pc.
REQ-009 SHALL have port predict_target, output, XLEN, predicted target for lookup_pc.
REQ-010 SHALL have port update_valid, input, 1, a resolved branch is presented this cycle.
REQ-011 SHALL have port update_pc, input, XLEN, PC of resolved branch.
REQ-012 SHALL have port update_target, input, XLEN, resolved target address.
REQ-013 SHALL have port update_taken, input, 1, resolved direction.
REQ-014 SHALL have port update_mispredicted, input, 1, prediction for this branch was wrong.

Function
REQ-015 SHALL compute index = pc[IDXW+1:2], tag = pc[XLEN-1:IDXW+2], IDXW = log2(ENTRIES); pc[1:0] ignored.
REQ-016 SHALL store per entry: valid bit, tag, XLEN target, 2-bit state.
REQ-017 SHALL encode state: 00 strong-taken, 01 weak-taken, 10 strong-not-taken, 11 weak-not-taken; predict taken iff state[1]==0.
REQ-018 SHALL compute state transitions by instantiating dynamic_branch_predictor (current_state = stored state, mispredicted = update_mispredicted): 00->01/00, 01->10/00, 10->11/10, 11->00/10 (mispredicted/correct).
REQ-019 SHALL drive lookup outputs combinationally from stored state, zero-cycle latency: btb_hit = valid && tag match; predict_taken = btb_hit && state[1]==0; predict_target = btb_hit ? stored target : 0.
REQ-020 SHALL, on update_valid with tag hit, write next state from REQ-018 and, if update_taken, write update_target; valid and tag unchanged.
REQ-021 SHALL, on update_valid with miss and update_taken=1, allocate: valid=1, tag, target=update_target, state=01; overwrite any previous occupant of that index.
REQ-022 SHALL, on update_valid with miss and update_taken=0, leave table unchanged.
REQ-023 SHALL write at most one entry per cycle; written values visible from the next cycle (subject to REQ-029).
REQ-024 SHALL, on flush, clear all valid bits next edge; targets and states retain values; flush takes priority over a same-cycle update (update dropped).
REQ-025 SHALL treat aliasing (same index, different tag) as miss; no replacement policy beyond overwrite.

Reset
REQ-026 SHALL, on rst sampled high, clear all valid bits, set all states to 01, all targets and tags to 0; rst has priority over flush and update.
REQ-027 SHALL drive btb_hit=0, predict_taken=0, predict_target=0 in the cycle after reset and until a branch is allocated.
REQ-028 SHALL discard any update presented in the same cycle as rst; reset mid-operation leaves no partial entry.

Configuration
REQ-029 SHALL, with macro BTB_BYPASS_EN defined, forward a same-cycle update (update_valid, no flush/rst) whose index and tag equal lookup_pc to the lookup outputs, showing post-write valid/state/target in that cycle.
REQ-030 SHALL, without BTB_BYPASS_EN, show pre-write contents for a same-cycle colliding lookup; new values appear next cycle.

Verification
REQ-031 SHALL cover: reset, lookup 0x100 -> btb_hit=0, predict_taken=0, predict_target=0.
REQ-032 SHALL cover: update pc=0x100 taken target=0x200 mispred=1; next cycle lookup 0x100 -> hit=1, taken=1, target=0x200, state 01.
REQ-033 SHALL cover: from state 01, two updates not-taken mispred=1 then not-taken mispred=0 -> states 10 then 10, predict_taken=0, target still 0x200.
REQ-034 SHALL cover: allocate 0x100, then taken update 0x140 (same index, ENTRIES=16) -> lookup 0x100 hit=0, lookup 0x140 hit=1.
REQ-035 SHALL cover: flush and update same cycle -> all lookups hit=0 next cycle, no allocation.
REQ-036 SHALL cover: same-cycle allocate and lookup of 0x300 -> hit=1 that cycle with BTB_BYPASS_EN, hit=0 that cycle and 1 next cycle without.
